dma_axi_rd_stream: RTL
======================

Name: dma_axi_rd_stream

Overview:
- Parametrised AXI4 read DMA engine for the DMA subsystem.
- Accepts a start address and a total word count, and splits the transfer into AXI INCR bursts.
- Each burst is no longer than MAX_BURST and, optionally, does not cross a 4 KB boundary.
- Read data is buffered in an internal FIFO and delivered on a valid/ready stream port; backpressure on the stream throttles burst issue.

Parameters:
- ADDR_W, 32: AXI address width.
- DATA_W, 32: AXI/stream data width. Power of 2, 32..256.
- LEN_W, 16: width of the total transfer length in words.
- MAX_BURST, 16: maximum beats per burst. Power of 2, 1..256.
- FIFO_AW, 5: log2 of FIFO depth. Must satisfy 2**FIFO_AW >= MAX_BURST.
- ID_W, 1: AXI ID width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  1-cycle pulse that launches a transfer; ignored while busy=1
- start_addr  in  ADDR_W  byte address, aligned to DATA_W/8
- xfer_len  in  LEN_W  transfer length in words; 0 = no-op
- busy  out  1  transfer in progress
- done  out  1  1-cycle pulse at transfer completion
- error  out  1  sticky error flag, cleared by the next accepted start
- out_valid  out  1  stream data valid
- out_data  out  DATA_W  stream data
- out_ready  in  1  stream consumer ready
- m_axi_arid  out  ID_W  constant 0
- m_axi_araddr  out  ADDR_W  burst address
- m_axi_arlen  out  8  burst length minus 1
- m_axi_arsize  out  3  constant log2(DATA_W/8)
- m_axi_arburst  out  2  constant 2'b01 (INCR)
- m_axi_arlock  out  1  constant 0
- m_axi_arcache  out  4  constant 4'b0011
- m_axi_arprot  out  3  constant 0
- m_axi_arqos  out  4  constant 0
- m_axi_arvalid  out  1  address valid
- m_axi_arready  in  1  address ready
- m_axi_rid  in  ID_W  ignored
- m_axi_rdata  in  DATA_W  read data
- m_axi_rresp  in  2  read response
- m_axi_rlast  in  1  last beat of burst
- m_axi_rvalid  in  1  read data valid
- m_axi_rready  out  1  read data ready

Behaviour:
- Reset values: busy, done, error, out_valid, arvalid and rready are 0; FIFO is empty; state is IDLE; araddr and arlen are 0.
- Reset mid-transfer (asynchronous) aborts immediately: FIFO flushed, arvalid dropped, outstanding beats forgotten.
- Single outstanding burst at a time. States are IDLE, CALC, ADDR, DATA, DRAIN.
- IDLE:
  - start with xfer_len=0: done pulses the next cycle, busy stays 0, error is cleared.
  - start with xfer_len>0: latch addr and remaining, clear error, busy=1, go to CALC.
- CALC:
  - blen = min(remaining, MAX_BURST, words to the next 4 KB boundary). The boundary term applies only when the feature is enabled; words to boundary = (4096 - addr[11:0]) >> log2(DATA_W/8).
  - Wait until FIFO free slots >= blen, then register araddr=addr and arlen=blen-1, and go to ADDR.
- ADDR:
  - arvalid=1, and araddr/arlen are held stable until arready.
  - On the arvalid & arready cycle, go to DATA.
- DATA:
  - rready=1; FIFO space is guaranteed by CALC.
  - Every rvalid beat is pushed and the beat counter is incremented.
  - rresp != 2'b00 sets error; the data is still pushed.
  - The burst ends on beat number blen. If rlast disagrees with (beat == blen-1), set error.
  - At burst end: addr += blen*(DATA_W/8), remaining -= blen. If remaining == 0, go to DRAIN; otherwise go to CALC.
- DRAIN: when the FIFO is empty, pulse done, drop busy and go to IDLE.
- Stream side:
  - First-word fall-through FIFO; out_data is valid while out_valid=1.
  - A pop occurs when out_valid & out_ready.
  - Push to out_valid latency is 1 cycle.
  - Simultaneous push and pop are supported in the same cycle, including when the FIFO is full or empty.
- Arithmetic: address wraps modulo 2**ADDR_W; remaining never underflows because blen <= remaining.

Optional Feature:
- Macro: DMA_AXI_4K_BOUNDARY_EN.
- Defined: bursts are additionally clipped so that no burst crosses a 4 KB address boundary, as AXI requires.
- Undefined: bursts are limited only by MAX_BURST and remaining. The integrator guarantees that the address map makes boundary crossing safe; area is smaller.

Test Plan:
- Basic transfer: start_addr=0x1000, xfer_len=40, MAX_BURST=16, out_ready=1 -> ARs (0x1000,15), (0x1040,15), (0x1080,7); 40 words out in order; one done pulse; error=0.
- 4 KB split, feature on: start_addr=0x0FF0, xfer_len=8, DATA_W=32 -> ARs (0x0FF0,3), (0x1000,3). Same stimulus with the feature off -> single AR (0x0FF0,7).
- Backpressure: FIFO_AW=5, xfer_len=64, out_ready=0 for 200 cycles -> exactly 2 bursts of 16 issued, then no arvalid until pops free 16 slots; no data lost.
- Error response: rresp=2'b10 on beat 3 of 8 -> all 8 words delivered, error=1 after done; a new start clears error.
- Zero length and reset: xfer_len=0 -> done the next cycle, no AR issued. Assert rst during DATA -> all outputs at reset values the same cycle; a following transfer completes correctly.

Source files
------------

// File: rtl/dma_axi_rd_stream.sv
// dma_axi_rd_stream: AXI4 read DMA that splits a word transfer into INCR bursts and streams the data out through a FWFT FIFO
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start/start_addr/xfer_len  launch a transfer of xfer_len words from start_addr (0 = no-op)
//   busy/done/error     status: in progress, 1-cycle completion pulse, sticky error
//   out_valid/out_data/out_ready  read data stream
//   m_axi_ar*           AXI4 read address channel (one burst outstanding)
//   m_axi_r*            AXI4 read data channel
//
// Optional feature: define DMA_AXI_4K_BOUNDARY_EN to clip bursts at 4 KB boundaries.
module dma_axi_rd_stream #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int LEN_W     = 16,
   parameter int MAX_BURST = 16,
   parameter int FIFO_AW   = 5,
   parameter int ID_W      = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [LEN_W-1:0]  xfer_len,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
   output logic [ID_W-1:0]   m_axi_arid,
   output logic [ADDR_W-1:0] m_axi_araddr,
   output logic [7:0]        m_axi_arlen,
   output logic [2:0]        m_axi_arsize,
   output logic [1:0]        m_axi_arburst,
   output logic              m_axi_arlock,
   output logic [3:0]        m_axi_arcache,
   output logic [2:0]        m_axi_arprot,
   output logic [3:0]        m_axi_arqos,
   output logic              m_axi_arvalid,
   input  logic              m_axi_arready,
   input  logic [ID_W-1:0]   m_axi_rid,
   input  logic [DATA_W-1:0] m_axi_rdata,
   input  logic [1:0]        m_axi_rresp,
   input  logic              m_axi_rlast,
   input  logic              m_axi_rvalid,
   output logic              m_axi_rready
);
   localparam int SZ    = $clog2(DATA_W / 8);
   localparam int BL_W  = $clog2(MAX_BURST) + 1;
   localparam int FW    = FIFO_AW + 1;
   localparam int DEPTH = 1 << FIFO_AW;

   typedef enum logic [2:0] {S_IDLE, S_CALC, S_ADDR, S_DATA, S_DRAIN} state_t;

   state_t            r_state, w_next;
   logic [ADDR_W-1:0] r_addr, r_araddr;
   logic [LEN_W-1:0]  r_rem;
   logic [BL_W-1:0]   r_blen, r_beat, w_cap, w_blen;
   logic [7:0]        r_arlen;
   logic              r_done, r_err;
   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [FIFO_AW-1:0] r_wp, r_rp;
   logic [FW-1:0]     r_cnt, w_free;
   logic              w_beat, w_last, w_pop, w_room, w_unused;

   assign w_unused = ^m_axi_rid;

   assign w_cap = (r_rem > LEN_W'(MAX_BURST)) ? BL_W'(MAX_BURST) : BL_W'(r_rem);
`ifdef DMA_AXI_4K_BOUNDARY_EN
   logic [12:0] w_b2b;
   // words left before the next 4 KB page; always >= 1 for aligned addresses
   assign w_b2b  = (13'd4096 - {1'b0, r_addr[11:0]}) >> SZ;
   assign w_blen = (13'(w_cap) > w_b2b) ? BL_W'(w_b2b) : w_cap;
`else
   assign w_blen = w_cap;
`endif

   // a burst is only issued once the FIFO can absorb all of it, so rready never stalls
   assign w_free = FW'(DEPTH) - r_cnt;
   assign w_room = w_free >= FW'(w_blen);
   assign w_beat = (r_state == S_DATA) && m_axi_rvalid;
   assign w_last = r_beat == r_blen - 1'b1;
   assign w_pop  = out_valid && out_ready;

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  w_next = (start && xfer_len != '0) ? S_CALC : S_IDLE;
         S_CALC:  w_next = w_room ? S_ADDR : S_CALC;
         S_ADDR:  w_next = m_axi_arready ? S_DATA : S_ADDR;
         S_DATA:  w_next = !(w_beat && w_last) ? S_DATA : (r_rem == LEN_W'(r_blen)) ? S_DRAIN : S_CALC;
         S_DRAIN: w_next = (r_cnt == '0) ? S_IDLE : S_DRAIN;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_addr   <= '0;
         r_rem    <= '0;
         r_blen   <= '0;
         r_beat   <= '0;
         r_araddr <= '0;
         r_arlen  <= '0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_done <= (r_state == S_IDLE && start && xfer_len == '0) || (r_state == S_DRAIN && r_cnt == '0);
         if (r_state == S_IDLE && start) begin
            r_err  <= 1'b0;
            r_addr <= start_addr;
            r_rem  <= xfer_len;
         end
         if (r_state == S_CALC && w_room) begin
            r_blen   <= w_blen;
            r_beat   <= '0;
            r_araddr <= r_addr;
            r_arlen  <= 8'(w_blen - 1'b1);
         end
         if (w_beat) begin
            r_beat <= r_beat + 1'b1;
            // bad response or rlast out of step with our own beat count; data is kept either way
            if (m_axi_rresp != 2'b00 || m_axi_rlast != w_last) r_err <= 1'b1;
            if (w_last) begin
               r_addr <= r_addr + (ADDR_W'(r_blen) << SZ);
               r_rem  <= r_rem - LEN_W'(r_blen);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_beat) r_mem[r_wp] <= m_axi_rdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         r_wp  <= r_wp + FIFO_AW'(w_beat);
         r_rp  <= r_rp + FIFO_AW'(w_pop);
         r_cnt <= r_cnt + FW'(w_beat) - FW'(w_pop);
      end
   end

   assign busy          = r_state != S_IDLE;
   assign done          = r_done;
   assign error         = r_err;
   assign out_valid     = r_cnt != '0;
   assign out_data      = r_mem[r_rp];
   assign m_axi_arid    = '0;
   assign m_axi_araddr  = r_araddr;
   assign m_axi_arlen   = r_arlen;
   assign m_axi_arsize  = 3'(SZ);
   assign m_axi_arburst = 2'b01;
   assign m_axi_arlock  = 1'b0;
   assign m_axi_arcache = 4'b0011;
   assign m_axi_arprot  = 3'b000;
   assign m_axi_arqos   = 4'b0000;
   assign m_axi_arvalid = r_state == S_ADDR;
   assign m_axi_rready  = r_state == S_DATA;
endmodule
